// File: rtl/gearbox_pkg.sv
// Shared constants, state type and helpers for the gearbox source arbiter.
package gearbox_pkg;

    localparam int unsigned WORDS_PER_GROUP = 3;
    localparam int unsigned PIX_W           = 24;
    localparam int unsigned WORD_W          = 32;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    // A packet is pixel-aligned when its word count fills whole 4-pixel groups.
    function automatic logic group_aligned(input logic [31:0] words);
        return (words % WORDS_PER_GROUP) == 32'd0;
    endfunction

endpackage

// File: rtl/gbx_rr_pick.sv
// Two-way round-robin priority picker: ptr selects which requester wins a tie.
module gbx_rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (!ptr) begin
            if (req[0]) begin
                gnt = 2'b01;
            end else if (req[1]) begin
                gnt = 2'b10;
            end
        end else begin
            if (req[1]) begin
                gnt = 2'b10;
            end else if (req[0]) begin
                gnt = 2'b01;
            end
        end
    end

endmodule

// File: rtl/gearbox_src_arbiter.sv
// Packet-level round-robin arbiter feeding the shared 32->24 gearbox input.
// Optional mid-packet stall timeout is enabled with GBX_ARB_TIMEOUT_EN.
module gearbox_src_arbiter
    import gearbox_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned CNT_W   = 16
`ifdef GBX_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic                      clk_200m,
    input  logic                      reset,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_last,
    input  logic [NUM_SRC*WORD_W-1:0] src_data,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      gb_ready,
    output logic                      data_en,
    output logic                      data_in_last,
    output logic [WORD_W-1:0]         data_in_rgb,
    output logic [NUM_SRC-1:0]        grant,
    output logic [CNT_W-1:0]          pkt_words,
    output logic                      pkt_done,
    output logic                      err_misalign
`ifdef GBX_ARB_TIMEOUT_EN
    ,
    output logic                      err_timeout
`endif
);

    arb_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic               rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   wcnt_q, wcnt_d;
    logic               data_en_q, data_en_d;
    logic               data_last_q, data_last_d;
    logic [WORD_W-1:0]  rgb_q, rgb_d;
    logic [CNT_W-1:0]   pkt_words_q, pkt_words_d;
    logic               pkt_done_q, pkt_done_d;
    logic               err_mis_q, err_mis_d;

    logic [NUM_SRC-1:0] pick_gnt;
    logic               owner;
    logic               owner_last;
    logic [WORD_W-1:0]  owner_data;
    logic               accept;
    logic               last_accept;
    logic [CNT_W-1:0]   cnt_inc;

`ifdef GBX_ARB_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              err_to_q, err_to_d;
    logic              owner_valid;

    assign owner_valid = owner ? src_valid[1] : src_valid[0];
    assign err_timeout = err_to_q;
`endif

    gbx_rr_pick u_pick (
        .req (src_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt)
    );

    // Grant is one-hot, so bit 1 alone identifies the owner.
    assign owner      = grant_q[1];
    assign owner_last = owner ? src_last[1] : src_last[0];
    assign owner_data = owner ? src_data[WORD_W +: WORD_W] : src_data[0 +: WORD_W];

    assign src_ready   = grant_q & {NUM_SRC{gb_ready & (state_q == ST_BUSY)}};
    assign accept      = |(src_valid & src_ready);
    assign last_accept = accept & owner_last;
    assign cnt_inc     = (&wcnt_q) ? wcnt_q : wcnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        wcnt_d      = wcnt_q;
        data_en_d   = accept;
        data_last_d = last_accept;
        rgb_d       = accept ? owner_data : rgb_q;
        pkt_words_d = pkt_words_q;
        pkt_done_d  = 1'b0;
        err_mis_d   = err_mis_q;
`ifdef GBX_ARB_TIMEOUT_EN
        idle_d      = idle_q;
        err_to_d    = err_to_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (|src_valid) begin
                    grant_d = pick_gnt;
                    state_d = ST_BUSY;
                    wcnt_d  = '0;
`ifdef GBX_ARB_TIMEOUT_EN
                    idle_d  = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (accept) begin
                    wcnt_d = cnt_inc;
                end
                if (last_accept) begin
                    state_d     = ST_IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = ~owner;
                    pkt_words_d = cnt_inc;
                    pkt_done_d  = 1'b1;
                    if (!group_aligned(32'(cnt_inc))) begin
                        err_mis_d = 1'b1;
                    end
                end
`ifdef GBX_ARB_TIMEOUT_EN
                if (accept) begin
                    idle_d = '0;
                end else if (!owner_valid) begin
                    if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        // Close the stalled packet with a zero filler word.
                        data_en_d   = 1'b1;
                        data_last_d = 1'b1;
                        rgb_d       = '0;
                        pkt_done_d  = 1'b1;
                        pkt_words_d = cnt_inc;
                        err_to_d    = 1'b1;
                        rr_ptr_d    = ~owner;
                        grant_d     = '0;
                        state_d     = ST_IDLE;
                        idle_d      = '0;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_200m) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= 1'b0;
            wcnt_q      <= '0;
            data_en_q   <= 1'b0;
            data_last_q <= 1'b0;
            rgb_q       <= '0;
            pkt_words_q <= '0;
            pkt_done_q  <= 1'b0;
            err_mis_q   <= 1'b0;
`ifdef GBX_ARB_TIMEOUT_EN
            idle_q      <= '0;
            err_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            wcnt_q      <= wcnt_d;
            data_en_q   <= data_en_d;
            data_last_q <= data_last_d;
            rgb_q       <= rgb_d;
            pkt_words_q <= pkt_words_d;
            pkt_done_q  <= pkt_done_d;
            err_mis_q   <= err_mis_d;
`ifdef GBX_ARB_TIMEOUT_EN
            idle_q      <= idle_d;
            err_to_q    <= err_to_d;
`endif
        end
    end

    assign data_en      = data_en_q;
    assign data_in_last = data_last_q;
    assign data_in_rgb  = rgb_q;
    assign grant        = grant_q;
    assign pkt_words    = pkt_words_q;
    assign pkt_done     = pkt_done_q;
    assign err_misalign = err_mis_q;

endmodule

// File: tb/tb_gearbox_src_arbiter.sv
// Self-checking bench: queued source packets, packet-order reference model, randomized
// data, gearbox backpressure and owner stalls.
module tb_gearbox_src_arbiter;

    logic        clk_200m = 1'b0;
    logic        reset;
    logic [1:0]  src_valid, src_last, src_ready, grant;
    logic [63:0] src_data;
    logic        gb_ready, data_en, data_in_last, pkt_done, err_misalign;
    logic [31:0] data_in_rgb;
    logic [15:0] pkt_words;
`ifdef GBX_ARB_TIMEOUT_EN
    logic        err_timeout;
`endif

    gearbox_src_arbiter dut (
        .clk_200m     (clk_200m),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_data     (src_data),
        .src_ready    (src_ready),
        .gb_ready     (gb_ready),
        .data_en      (data_en),
        .data_in_last (data_in_last),
        .data_in_rgb  (data_in_rgb),
        .grant        (grant),
        .pkt_words    (pkt_words),
        .pkt_done     (pkt_done),
        .err_misalign (err_misalign)
`ifdef GBX_ARB_TIMEOUT_EN
        ,
        .err_timeout  (err_timeout)
`endif
    );

    always #5 clk_200m = ~clk_200m;

    // Source-side word queues and not-yet-planned packet lengths.
    logic [31:0] sq_data [2][$];
    bit          sq_last [2][$];
    int          pk_len  [2][$];

    // Expected gearbox stream and per-packet expectations, in grant order.
    logic [31:0] exp_data[$];
    bit          exp_last[$];
    int          exp_len[$];
    int          exp_src[$];

    bit   mid_pkt[2];
    int   rr_model;
    bit   err_model;
    int   gb_mode, stall_pct;
    bit   hold_src, gap_pending;
    int   cyc, acc_cnt, en_cnt;
    logic prev_gb;
    int   n_checks, n_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        for (int i = 0; i < len; i++) begin
            sq_data[s].push_back($urandom);
            sq_last[s].push_back(i == len - 1);
        end
        pk_len[s].push_back(len);
    endtask

    // Packet order: after a packet from s, ~s is preferred if it has one waiting.
    task automatic plan();
        int idx[2];
        int s, len;
        idx[0] = 0;
        idx[1] = 0;
        while (pk_len[0].size() + pk_len[1].size() > 0) begin
            s   = (pk_len[rr_model].size() > 0) ? rr_model : 1 - rr_model;
            len = pk_len[s].pop_front();
            for (int i = 0; i < len; i++) begin
                exp_data.push_back(sq_data[s][idx[s]]);
                exp_last.push_back(i == len - 1);
                idx[s]++;
            end
            exp_len.push_back(len);
            exp_src.push_back(s);
            rr_model = 1 - s;
        end
    endtask

    task automatic step();
        logic [1:0]  v, l, om;
        logic [31:0] d[2];
        logic        gb;
        bit          stall;
        logic [31:0] ed;
        bit          el;
        int          len;
        for (int s = 0; s < 2; s++) begin
            stall = mid_pkt[s] && ($urandom_range(0, 99) < stall_pct);
            if (!hold_src && sq_data[s].size() > 0 && !stall) begin
                v[s] = 1'b1;
                d[s] = sq_data[s][0];
                l[s] = sq_last[s][0];
            end else begin
                v[s] = 1'b0;
                d[s] = $urandom;
                l[s] = 1'($urandom_range(0, 1));
            end
        end
        case (gb_mode)
            0:       gb = 1'b1;
            1:       gb = ((cyc / 2) % 2) == 0;
            default: gb = 1'($urandom_range(0, 1));
        endcase
        src_valid = v;
        src_last  = l;
        src_data  = {d[1], d[0]};
        gb_ready  = gb;
        #1;
        om = 2'b00;
        if (exp_src.size() > 0) om = (exp_src[0] == 0) ? 2'b01 : 2'b10;
        if (gap_pending) check("idle_gap_ready", 32'(src_ready), 32'd0);
        else if (exp_src.size() > 0) check("non_owner_ready", 32'(src_ready & ~om), 32'd0);
        gap_pending = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (v[s] && src_ready[s]) begin
                void'(sq_data[s].pop_front());
                void'(sq_last[s].pop_front());
                mid_pkt[s] = !l[s];
                acc_cnt++;
                if (l[s]) gap_pending = 1'b1;
            end
        end
        prev_gb = gb;
        @(posedge clk_200m);
        #1;
        cyc++;
        if (data_en) begin
            en_cnt++;
            check("en_after_gb_low", 32'(prev_gb), 32'd1);
            if (exp_data.size() == 0) begin
                check("extra_word", 32'(data_en), 32'd0);
            end else begin
                ed = exp_data.pop_front();
                el = exp_last.pop_front();
                check("rgb", data_in_rgb, ed);
                check("last", 32'(data_in_last), 32'(el));
                if (el) begin
                    len       = exp_len.pop_front();
                    err_model = err_model | ((len % 3) != 0);
                    void'(exp_src.pop_front());
                    check("pkt_done", 32'(pkt_done), 32'd1);
                    check("pkt_words", 32'(pkt_words), 32'(len));
                    check("err_misalign", 32'(err_misalign), 32'(err_model));
                    check("grant_release", 32'(grant), 32'd0);
                end else begin
                    check("grant_owner", 32'(grant), 32'(om));
                    check("done_mid_pkt", 32'(pkt_done), 32'd0);
                end
            end
        end else begin
            check("last_without_en", 32'(data_in_last), 32'd0);
            check("done_without_en", 32'(pkt_done), 32'd0);
        end
    endtask

    task automatic run_until_done(input string tag, input int budget);
        int n = 0;
        while (exp_data.size() > 0 && n < budget) begin
            step();
            n++;
        end
        check({tag, "_drained"}, 32'(exp_data.size()), 32'd0);
        step();
    endtask

    task automatic do_reset(input int cycles);
        exp_data.delete();
        exp_last.delete();
        exp_len.delete();
        exp_src.delete();
        for (int s = 0; s < 2; s++) begin
            sq_data[s].delete();
            sq_last[s].delete();
            pk_len[s].delete();
            mid_pkt[s] = 1'b0;
        end
        gap_pending = 1'b0;
        hold_src    = 1'b1;
        reset       = 1'b1;
        for (int i = 0; i < cycles; i++) step();
        check("rst_data_en", 32'(data_en), 32'd0);
        check("rst_last", 32'(data_in_last), 32'd0);
        check("rst_rgb", data_in_rgb, 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_pkt_words", 32'(pkt_words), 32'd0);
        check("rst_pkt_done", 32'(pkt_done), 32'd0);
        check("rst_err", 32'(err_misalign), 32'd0);
        check("rst_ready", 32'(src_ready), 32'd0);
        reset     = 1'b0;
        hold_src  = 1'b0;
        rr_model  = 0;
        err_model = 1'b0;
    endtask

    initial begin
        int n, e0;
        n_checks  = 0;
        n_err     = 0;
        cyc       = 0;
        acc_cnt   = 0;
        en_cnt    = 0;
        gb_mode   = 0;
        stall_pct = 0;
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        gb_ready  = 1'b0;
        do_reset(3);

        // Src0 alone, 9 words, known leading pattern.
        add_pkt(0, 9);
        sq_data[0][0] = 32'hB0A2A1A0;
        sq_data[0][1] = 32'hC1C0B2B1;
        sq_data[0][2] = 32'hD2D1D0C2;
        plan();
        e0 = en_cnt;
        run_until_done("src0_9", 100);
        check("src0_9_en_count", 32'(en_cnt - e0), 32'd9);
        check("src0_9_err", 32'(err_misalign), 32'd0);

        // Simultaneous requests straight after reset: src0 wins.
        do_reset(2);
        add_pkt(0, 6);
        add_pkt(1, 3);
        plan();
        run_until_done("both_req", 100);

        // Misaligned 10-word packet, then an aligned one keeps the sticky error.
        add_pkt(1, 10);
        plan();
        run_until_done("src1_10", 100);
        add_pkt(0, 6);
        plan();
        run_until_done("after_err", 100);
        check("err_sticky", 32'(err_misalign), 32'd1);

        // Gearbox ready toggling every two cycles.
        gb_mode = 1;
        add_pkt(1, 6);
        plan();
        run_until_done("gb_toggle", 200);

        // Random lengths, random backpressure, owner stalls mid-packet.
        gb_mode   = 2;
        stall_pct = 30;
        for (int i = 0; i < 5; i++) begin
            add_pkt(0, $urandom_range(1, 8));
            add_pkt(1, $urandom_range(1, 8));
        end
        plan();
        run_until_done("random", 3000);

        // Reset after the fourth word of a 9-word packet.
        gb_mode   = 0;
        stall_pct = 0;
        add_pkt(0, 9);
        plan();
        acc_cnt = 0;
        n       = 0;
        while (acc_cnt < 4 && n < 100) begin
            step();
            n++;
        end
        check("rst_mid_accepts", 32'(acc_cnt), 32'd4);
        do_reset(1);

        // Single-word packet after reset: count restarts, misaligned.
        add_pkt(0, 1);
        plan();
        run_until_done("single_word", 50);
        check("single_err", 32'(err_misalign), 32'd1);
        check("single_words", 32'(pkt_words), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
